// File: rtl/sub_bytes_engine.sv
// Multi-lane AES SubBytes engine: accepts one word, substitutes LANES bytes
// per cycle through forward/inverse S-boxes, then holds the result until taken.
module sub_bytes_engine #(
  parameter int NUM_BYTES = 16,
  parameter int LANES     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_data,
  input  logic                   in_inverse,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_data,
  output logic                   busy
);

  localparam int CHUNKS = NUM_BYTES / LANES;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNKS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16) ||
      (NUM_BYTES % LANES) != 0) begin : g_param_check
    $error("sub_bytes_engine: LANES must be 1/2/4/8/16 and divide NUM_BYTES");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic                     mode_q;
  logic [8*NUM_BYTES-1:0]   data_q;
  logic [8*NUM_BYTES-1:0]   result_q;
  logic [8*LANES-1:0]       lane_out;
  logic                     last_chunk;

  // The S-boxes are built arithmetically (GF(2^8) inverse plus affine map)
  // rather than as literal tables; both directions share the inverter.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // x^254 = x^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r, t;
    r = 8'h01;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, t);
      t = gf_mul(t, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] y;
    y = gf_inv(x);
    return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  assign last_chunk = (cnt_q == LAST_CNT);
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_data   = result_q;

  // Substitute the current chunk of bytes through all lanes in parallel.
  always_comb begin
    int         idx;
    logic [7:0] b;
    lane_out = '0;
    idx      = 0;
    b        = '0;
    for (int l = 0; l < LANES; l++) begin
      idx = int'(cnt_q) * LANES + l;
      b   = data_q[8*(NUM_BYTES-1-idx) +: 8];
      lane_out[8*l +: 8] = mode_q ? sbox_inv(b) : sbox_fwd(b);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = BUSY;
      BUSY:    if (last_chunk) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture on acceptance, then write one chunk of results per BUSY cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      data_q   <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            mode_q <= in_inverse;
            cnt_q  <= '0;
          end
        end
        BUSY: begin
          for (int l = 0; l < LANES; l++)
            result_q[8*(NUM_BYTES-1-(int'(cnt_q)*LANES+l)) +: 8] <= lane_out[8*l +: 8];
          cnt_q <= last_chunk ? '0 : cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Scoreboard bench for sub_bytes_engine: driver pushes expected words,
// a monitor pops and compares on each output handoff; plus a LANES sweep.
module tb_sub_bytes_engine;

  localparam int NB  = 16;
  localparam int LAT = 4;

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  logic         clk = 0;
  logic         rst = 1;
  logic         in_valid = 0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         in_inverse = 0;
  logic         out_valid;
  logic         out_ready = 0;
  logic [127:0] out_data;
  logic         busy;

  int errors = 0;
  int checks = 0;
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

  sub_bytes_engine #(.NUM_BYTES(NB), .LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inverse(in_inverse), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  // Sweep instances, LANES = 1, 2, 4, 8, 16.
  logic [4:0]   sw_in_valid = '0;
  logic [4:0]   sw_in_ready, sw_out_valid, sw_busy;
  logic [127:0] sw_data = '0;
  logic [127:0] sw_out_data [5];

  for (genvar g = 0; g < 5; g++) begin : g_sweep
    sub_bytes_engine #(.NUM_BYTES(NB), .LANES(1 << g)) u_sw (
      .clk(clk), .rst(rst), .in_valid(sw_in_valid[g]), .in_ready(sw_in_ready[g]),
      .in_data(sw_data), .in_inverse(1'b0), .out_valid(sw_out_valid[g]),
      .out_ready(1'b1), .out_data(sw_out_data[g]), .busy(sw_busy[g])
    );
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] junk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: compare every output handoff against the scoreboard head.
  always begin
    @(negedge clk);
    #3;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", out_data);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic inv, input logic [127:0] exp,
                      input int stall);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", {127'd0, in_ready}, 128'd1);
    in_data = d;
    in_inverse = inv;
    in_valid = 1;
    out_ready = 0;
    @(posedge clk);
    #1;
    exp_q.push_back(exp);
    check("busy_after_accept", {127'd0, busy}, 128'd1);
    // Inputs keep wiggling while busy; they must be ignored.
    n = 0;
    do begin
      in_data = junk();
      in_inverse = ~inv;
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 40);
    check("latency", n, LAT);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_data = junk();
      check("stall_data", out_data, exp);
      check("stall_in_ready", {127'd0, in_ready}, 128'd0);
    end
    @(negedge clk);
    out_ready = 1;
    in_data = junk();
    @(posedge clk);
    #1;
    check("post_handoff_in_ready", {127'd0, in_ready}, 128'd1);
    check("post_handoff_out_valid", {127'd0, out_valid}, 128'd0);
    in_valid = 0;
    out_ready = 0;
  endtask

  initial begin
    int lat [5];
    logic [127:0] got [5];
    int quiet;

    #1;
    check("reset_out_valid", {127'd0, out_valid}, 128'd0);
    check("reset_busy", {127'd0, busy}, 128'd0);
    check("reset_out_data", out_data, 128'd0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    check("ready_after_reset", {127'd0, in_ready}, 128'd1);

    send(128'd0, 0, {16{8'h63}}, 0);
    send(FIPS_IN, 0, FIPS_OUT, 0);
    send(FIPS_OUT, 1, FIPS_IN, 0);
    send({8{8'h63, 8'h16}}, 1, {8{8'h00, 8'hff}}, 0);
    send(FIPS_IN, 0, FIPS_OUT, 10);

    // Reset during the second BUSY cycle discards the word.
    @(negedge clk);
    in_data = FIPS_IN;
    in_inverse = 0;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    check("midbusy_rst_busy", {127'd0, busy}, 128'd0);
    check("midbusy_rst_out_data", out_data, 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) quiet++;
    end
    check("no_output_after_rst", quiet, 0);
    check("ready_after_rst", {127'd0, in_ready}, 128'd1);
    send({16{8'hff}}, 0, {16{8'h16}}, 0);

    // Sweep: all lane counts fed the same vector at once.
    @(negedge clk);
    sw_data = FIPS_IN;
    sw_in_valid = '1;
    @(posedge clk);
    #1;
    sw_in_valid = '0;
    for (int g = 0; g < 5; g++) begin
      lat[g] = 0;
      got[g] = '0;
    end
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 5; g++)
        if (sw_out_valid[g] && lat[g] == 0) begin
          lat[g] = c;
          got[g] = sw_out_data[g];
        end
    end
    for (int g = 0; g < 5; g++) begin
      check($sformatf("sweep_latency_lanes%0d", 1 << g), lat[g], 16 >> g);
      check($sformatf("sweep_data_lanes%0d", 1 << g), got[g], FIPS_OUT);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
